// File: rtl/uart_tx_ext.sv
// uart_tx_ext: FIFO-buffered UART transmitter, LSB first, idle-high line.
// Define UART_TX_PARITY_EN to add the i_parity_odd port and a parity bit after the data.
module uart_tx_ext #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_tx_valid,
  input  logic [DATA_BITS-1:0]          i_tx_data,
  output logic                          o_tx_ready,
`ifdef UART_TX_PARITY_EN
  input  logic                          i_parity_odd,
`endif
  output logic                          o_tx_serial,
  output logic                          o_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = CPB > 1 ? $clog2(CPB) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]          fcnt_q, fcnt_d;
  state_t               state_q, state_d;
  logic [CW-1:0]        clk_q, clk_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 tx_q, tx_d;
  logic                 push, pop, bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif
  assign o_tx_ready   = fcnt_q < (AW+1)'(FIFO_DEPTH);
  assign o_tx_busy    = state_q != IDLE || fcnt_q != '0;
  assign o_fifo_count = fcnt_q;
  assign o_tx_serial  = tx_q;
  always_comb begin
    push    = i_tx_valid && o_tx_ready;
    bit_end = clk_q == CW'(CPB - 1);
    // Popping at the end of the last stop bit chains frames with no idle cycle.
    pop     = fcnt_q != '0 && (state_q == IDLE ||
              (state_q == STOP && bit_end && bit_q == 4'(STOP_BITS - 1)));
    state_d = state_q;
    clk_d   = bit_end ? '0 : clk_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE:  clk_d = '0;
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (bit_end) begin
        sh_d  = sh_q >> 1;
        bit_d = bit_q + 1'b1;
        if (bit_q == 4'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
          bit_d = '0;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) begin
        state_d = STOP;
        bit_d   = '0;
      end
`endif
      STOP: if (bit_end) begin
        bit_d = bit_q + 1'b1;
        if (bit_q == 4'(STOP_BITS - 1)) begin
          state_d = IDLE;
          bit_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        clk_d   = '0;
        bit_d   = '0;
      end
    endcase
    if (pop) begin
      state_d = START;
      clk_d   = '0;
      bit_d   = '0;
      sh_d    = mem_q[rd_q];
`ifdef UART_TX_PARITY_EN
      par_d   = ^mem_q[rd_q] ^ i_parity_odd;
`endif
    end
    wr_d   = wr_q + AW'(push);
    rd_d   = rd_q + AW'(pop);
    fcnt_d = fcnt_q + (AW+1)'(push) - (AW+1)'(pop);
`ifdef UART_TX_PARITY_EN
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : state_d == PARITY ? par_d : 1'b1;
`else
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : 1'b1;
`endif
  end
  always_ff @(posedge i_clk)
    if (push) mem_q[wr_q] <= i_tx_data;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      fcnt_q  <= '0;
      clk_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fcnt_q  <= fcnt_d;
      clk_q   <= clk_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
endmodule

// File: tb/tb_uart_tx_ext.sv
// tb_uart_tx_ext: scoreboard bench for uart_tx_ext with a short bit time, 2 stop bits and a 4-deep FIFO.
// A line monitor pops expected frames and checks every line cycle of each frame.
module tb_uart_tx_ext;
  localparam int CPB = 5;
  localparam int DB  = 8;
  localparam int SB  = 2;
  localparam int FD  = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = 1 + DB + PB + SB;
  localparam int FL = NB * CPB;

  logic          clk = 1'b0, rst = 1'b1, valid = 1'b0, par_odd = 1'b0;
  logic [DB-1:0] data = '0;
  logic          ser, busy, ready;
  logic [2:0]    fcount;
  int            total = 0, bad = 0, cyc = 0;
  logic [NB-1:0] exp_q[$];
  int            starts[$];

  uart_tx_ext #(
    .CLK_FREQ(CPB * 100), .BAUD_RATE(100), .DATA_BITS(DB), .STOP_BITS(SB), .FIFO_DEPTH(FD)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_tx_valid(valid),
    .i_tx_data(data),
    .o_tx_ready(ready),
`ifdef UART_TX_PARITY_EN
    .i_parity_odd(par_odd),
`endif
    .o_tx_serial(ser),
    .o_tx_busy(busy),
    .o_fifo_count(fcount)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NB-1:0] frame(input logic [DB-1:0] w, input logic po);
    logic [NB-1:0] f;
    f = '1;
    f[0] = 1'b0;
    f[DB:1] = w;
    if (PB == 1) f[DB+1] = ^w ^ po;
    return f;
  endfunction

  initial begin
    logic [NB-1:0] fb;
    bit ab;
    forever begin
      @(negedge clk);
      if (!rst && ser === 1'b0) begin
        starts.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_frame: start bit at cycle %0d, none expected", cyc);
          repeat (FL) @(negedge clk);
        end else begin
          fb = exp_q.pop_front();
          ab = 0;
          for (int b = 0; b < NB && !ab; b++)
            for (int c = 0; c < CPB && !ab; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (rst) ab = 1;
              else begin
                total++;
                if (ser !== fb[b]) begin
                  bad++;
                  $display("FAIL line_bit%0d_cyc%0d: got %b want %b at cycle %0d", b, c, ser, fb[b], cyc);
                end
              end
            end
        end
      end
    end
  end

  task automatic push(input logic [DB-1:0] w, input bit acc, output int k);
    valid = 1'b1;
    data  = w;
    @(posedge clk);
    if (acc) exp_q.push_back(frame(w, par_odd));
    @(negedge clk); #1;
    k = cyc;
    valid = 1'b0;
    data  = ~w;
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    total++; if (ser !== 1'b1) begin bad++; $display("FAIL reset_serial: got %b want 1", ser); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (fcount !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", fcount); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_single;
    int k;
    starts.delete();
    push(8'h55, 1, k);
    total++; if (fcount !== 3'd1) begin bad++; $display("FAIL single_count: got %0d want 1", fcount); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_queued: got %b want 1", busy); end
    @(negedge clk); #1;
    total++;
    if (starts.size() != 1 || starts[0] != k + 1) begin
      bad++; $display("FAIL single_start_latency: got %0d starts (first %0d) want 1 at %0d",
                      starts.size(), starts.size() > 0 ? starts[0] : -1, k + 1);
    end
    repeat (FL - 1) @(negedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_last_stop: got %b want 1", busy); end
    @(negedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL single_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    logic [DB-1:0] w [6] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    int k0, k;
    starts.delete();
    for (int i = 0; i < 5; i++) begin
      push(w[i], 1, k);
      if (i == 0) k0 = k;
    end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_full: got %b want 0", ready); end
    total++; if (fcount !== 3'd4) begin bad++; $display("FAIL b2b_count_full: got %0d want 4", fcount); end
    push(w[5], 0, k);
    total++; if (fcount !== 3'd4) begin bad++; $display("FAIL b2b_refused_count: got %0d want 4", fcount); end
    for (int i = 0; i < 6 * FL && (starts.size() < 5 || busy); i++) begin
      @(negedge clk); #1;
    end
    total++;
    if (starts.size() < 5) begin
      bad++; $display("FAIL b2b_frames: got %0d frames want 5", starts.size());
    end else begin
      if (starts[0] != k0 + 1) begin
        bad++; $display("FAIL b2b_first_start: got %0d want %0d", starts[0], k0 + 1);
      end
      for (int i = 1; i < 5; i++) begin
        total++;
        if (starts[i] - starts[i-1] != FL) begin
          bad++; $display("FAIL b2b_gap%0d: got %0d want %0d", i, starts[i] - starts[i-1], FL);
        end
      end
    end
    repeat (2 * FL) @(negedge clk);
    #1;
    total++; if (starts.size() != 5) begin bad++; $display("FAIL b2b_extra: got %0d frames want 5", starts.size()); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_stop_bits;
    int k;
    starts.delete();
    push(8'hFF, 1, k);
    push(8'h00, 1, k);
    for (int i = 0; i < 3 * FL && starts.size() < 2; i++) begin
      @(negedge clk); #1;
    end
    total++;
    if (starts.size() < 2 || starts[1] - starts[0] != FL) begin
      bad++; $display("FAIL stop_spacing: got %0d frames, spacing %0d want %0d", starts.size(),
                      starts.size() > 1 ? starts[1] - starts[0] : -1, FL);
    end
    repeat (FL + 2) @(negedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_idle: got busy %b want 0", busy); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    int k;
    logic want [2] = '{1'b1, 1'b0};
    for (int r = 0; r < 2; r++) begin
      par_odd = (r == 0);
      push(8'h41, 1, k);
      repeat ((1 + DB) * CPB + 2) @(negedge clk);
      #1;
      total++;
      if (ser !== want[r]) begin
        bad++; $display("FAIL parity_odd%0d: got %b want %b", par_odd, ser, want[r]);
      end
      repeat (FL) @(negedge clk);
      #1;
    end
    par_odd = 1'b0;
  endtask
`endif

  task automatic test_reset_mid;
    int k;
    starts.delete();
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 1, k);
    repeat (4 * CPB) @(negedge clk);
    #1;
    total++; if (fcount !== 3'd3) begin bad++; $display("FAIL mid_queued: got %0d want 3", fcount); end
    rst = 1'b1;
    #1;
    total++; if (ser !== 1'b1) begin bad++; $display("FAIL mid_line_high: got %b want 1", ser); end
    total++; if (fcount !== 3'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", fcount); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", ready); end
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    starts.delete();
    repeat (3 * FL) @(negedge clk);
    #1;
    total++; if (starts.size() != 0) begin bad++; $display("FAIL mid_silent: got %0d frames want 0", starts.size()); end
    push(8'h3C, 1, k);
    @(negedge clk); #1;
    total++;
    if (starts.size() != 1 || starts[0] != k + 1) begin
      bad++; $display("FAIL mid_repush_latency: got %0d starts (first %0d) want at %0d",
                      starts.size(), starts.size() > 0 ? starts[0] : -1, k + 1);
    end
    repeat (FL + 1) @(negedge clk);
    #1;
    total++; if (exp_q.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_repush_done: got %0d left busy %b want 0 and 0", exp_q.size(), busy);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_stop_bits;
`ifdef UART_TX_PARITY_EN
    test_parity;
`endif
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
